cpu_bus_responder: RTL and testbench
====================================

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port AddressBusHigh, input, 8 bits: CPU address [15:8].
REQ-004 SHALL have port AddressBusLow, input, 8 bits: CPU address [7:0].
REQ-005 SHALL have port readNotWrite, input, 1 bit: 1 = CPU read, 0 = CPU write.
REQ-006 SHALL have port dataBusEnable, input, 1 bit: CPU write data valid; qualifies writes.
REQ-007 SHALL have port dataBusOutput, input, 8 bits: CPU write data.
REQ-008 SHALL have port sync, input, 1 bit: CPU opcode-fetch cycle indicator.
REQ-009 SHALL have port dataBusInput, output, 8 bits: registered read data to CPU.
REQ-010 SHALL have port ready, output, 1 bit: CPU RDY; 0 stalls the CPU.
REQ-011 SHALL have port waitStates, input, 2 bits: opcode-fetch wait states, 0-3.
REQ-012 SHALL have port loadEnable, input, 1 bit: host preload request.
REQ-013 SHALL have port loadAddress, input, 16 bits: host preload address.
REQ-014 SHALL have port loadData, input, 8 bits: host preload data.
REQ-015 SHALL have port loadAck, output, 1 bit: one-cycle pulse, preload byte written.
REQ-016 SHALL have port unmappedAccess, output, 1 bit: one-cycle pulse on serviced access outside the map.

Function
REQ-017 Map: SHALL map 0x0000-0x03FF to RAM A (1 KiB; zero page, stack, 0x0200 code).
REQ-018 Map: SHALL map 0xCC00-0xCFFF to RAM B (1 KiB).
REQ-019 Map: SHALL map 0xFFFA-0xFFFF to six writable vector registers.
REQ-020 Unmapped addresses: reads SHALL return 0x00; writes SHALL be dropped; unmappedAccess SHALL pulse on either.
REQ-021 Serviced cycle: a rising edge with FSM in RUN and no stall starting.
REQ-022 Serviced read: dataBusInput SHALL take mem[{AddressBusHigh,AddressBusLow}] at the edge (1-cycle registered latency); dataBusInput otherwise holds.
REQ-023 Serviced write: when readNotWrite=0 and dataBusEnable=1, SHALL write dataBusOutput to the address; readNotWrite=0 with dataBusEnable=0 SHALL be a no-op.
REQ-024 FSM states: RUN, STALL, LOAD.
REQ-025 RUN -> STALL: when sync=1, waitStates!=0 and fetchDone=0; SHALL load counter=waitStates, drive ready=0, and not service the cycle.
REQ-026 STALL: SHALL keep ready=0 and decrement the counter each edge; at counter=1 SHALL return to RUN and set fetchDone=1.
REQ-027 Stall length: ready SHALL be low exactly waitStates cycles per opcode fetch.
REQ-028 fetchDone: SHALL clear on any edge with sync=0, so each new fetch stalls once.
REQ-029 waitStates=0: no stall; ready SHALL stay 1 in RUN.
REQ-030 LOAD priority: loadEnable=1 SHALL override CPU traffic; from RUN or STALL, SHALL enter LOAD.
REQ-031 LOAD: ready=0; each edge with loadEnable=1 SHALL write loadData to loadAddress, with loadAck=1 the following cycle.
REQ-032 LOAD unmapped: an unmapped loadAddress SHALL be dropped, with no loadAck and unmappedAccess=1.
REQ-033 LOAD -> RUN: on loadEnable=0; counter and fetchDone SHALL clear, so an interrupted stall restarts.
REQ-034 Simultaneous read of and load to the same address: not possible, because ready=0 in LOAD.
REQ-035 Address width: 16 bits; no wrap beyond 0xFFFF; RAM index = address[9:0] within each window.

Reset
REQ-036 While rst=1 at an edge: state=RUN, ready=0, dataBusInput=0x00, loadAck=0, unmappedAccess=0, counter=0, fetchDone=0.
REQ-037 First cycle after rst deasserts: ready SHALL be 1.
REQ-038 Vector reset values: FFFA=0x00, FFFB=0x02, FFFC=0xDC, FFFD=0xCC, FFFE=0xCA, FFFF=0xCC.
REQ-039 RAM contents SHALL NOT be reset; reset mid-LOAD or mid-STALL SHALL abort at that edge, with no further writes.

Verification
REQ-040 Reset, then read 0xFFFC then 0xFFFD, waitStates=0 -> dataBusInput 0xDC then 0xCC, each one cycle after address; ready=1 throughout.
REQ-041 Preload 0xCCDC=0xA9 and 0xCCDD=0x7F, then CPU reads with sync=1, waitStates=2 -> ready low 2 cycles per fetch, then 0xA9; the 0xCCDD read without sync returns 0x7F with no stall.
REQ-042 CPU write 0x01FF=0x55 with dataBusEnable=1, then read -> 0x55; write with dataBusEnable=0 -> value unchanged.
REQ-043 Read 0x8000; write 0x4000 -> read returns 0x00, unmappedAccess pulses on each, memory unchanged.
REQ-044 loadEnable asserted during STALL (waitStates=3) -> ready stays 0 and loadAck follows; on release the fetch stalls a full 3 cycles again.
REQ-045 Write 0xFFFE=0x34, then assert rst -> 0xFFFE reads 0xCA and a RAM A byte keeps its value.

Source files
------------

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus plus host preload port of the bus responder.
// The responder uses the slave modport; the CPU/host model uses master.
interface cpu_bus_responder_if;
  logic [7:0]  AddressBusHigh;
  logic [7:0]  AddressBusLow;
  logic        readNotWrite;
  logic        dataBusEnable;
  logic [7:0]  dataBusOutput;
  logic        sync;
  logic [7:0]  dataBusInput;
  logic        ready;
  logic [1:0]  waitStates;
  logic        loadEnable;
  logic [15:0] loadAddress;
  logic [7:0]  loadData;
  logic        loadAck;
  logic        unmappedAccess;

  modport slave (
    input  AddressBusHigh, AddressBusLow, readNotWrite, dataBusEnable, dataBusOutput, sync,
           waitStates, loadEnable, loadAddress, loadData,
    output dataBusInput, ready, loadAck, unmappedAccess
  );

  modport master (
    output AddressBusHigh, AddressBusLow, readNotWrite, dataBusEnable, dataBusOutput, sync,
           waitStates, loadEnable, loadAddress, loadData,
    input  dataBusInput, ready, loadAck, unmappedAccess
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory responder for an 8-bit CPU: two 1 KiB RAM windows, six vector registers,
// opcode-fetch wait states and a host preload port that takes priority over the CPU.
module cpu_bus_responder (
  input logic                  clk,
  input logic                  rst,
  cpu_bus_responder_if.slave   bus
);

  typedef enum logic [1:0] {StRun, StStall, StLoad} state_e;
  typedef enum logic [1:0] {RegNone, RegA, RegB, RegVec} region_e;

  function automatic region_e decode(input logic [15:0] a);
    if (a[15:10] == 6'b000000)      return RegA;
    else if (a[15:10] == 6'b110011) return RegB;
    else if (a >= 16'hfffa)         return RegVec;
    else                            return RegNone;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        fetch_done_q, fetch_done_d;
  logic [7:0]  rdata_q;
  logic        load_ack_q, load_ack_d;
  logic        unmapped_q, unmapped_d;
  logic [7:0]  ram_a [1024];
  logic [7:0]  ram_b [1024];
  logic [7:0]  vec_q [6];

  logic [15:0] cpu_addr;
  region_e     cpu_region, load_region, wr_region;
  logic        serviced, cpu_wr, wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, rd_data;
  logic [2:0]  rd_vidx, wr_vidx;

  assign cpu_addr    = {bus.AddressBusHigh, bus.AddressBusLow};
  assign cpu_region  = decode(cpu_addr);
  assign load_region = decode(bus.loadAddress);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fetch_done_d = fetch_done_q;
    serviced     = 1'b0;
    if (!bus.sync) fetch_done_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.loadEnable) begin
          state_d = StLoad;
        end else if (bus.sync && bus.waitStates != 2'd0 && !fetch_done_q) begin
          state_d = StStall;
          count_d = bus.waitStates;
        end else begin
          serviced = 1'b1;
        end
      end
      StStall: begin
        if (bus.loadEnable) begin
          state_d = StLoad;
        end else begin
          count_d = count_q - 2'd1;
          if (count_q <= 2'd1) begin
            state_d      = StRun;
            fetch_done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Leaving LOAD forgets any interrupted stall so the fetch stalls in full.
        if (!bus.loadEnable) begin
          state_d      = StRun;
          count_d      = 2'd0;
          fetch_done_d = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Single write port: a host preload always wins over CPU traffic.
  always_comb begin
    cpu_wr    = serviced && !bus.readNotWrite && bus.dataBusEnable;
    wr_en     = bus.loadEnable || cpu_wr;
    wr_addr   = bus.loadEnable ? bus.loadAddress : cpu_addr;
    wr_data   = bus.loadEnable ? bus.loadData : bus.dataBusOutput;
    wr_region = decode(wr_addr);
    wr_vidx   = wr_addr[2:0] - 3'd2;
    rd_vidx   = cpu_addr[2:0] - 3'd2;
    load_ack_d = bus.loadEnable && (load_region != RegNone);
    unmapped_d = (bus.loadEnable && load_region == RegNone) ||
                 (serviced && (bus.readNotWrite || bus.dataBusEnable) &&
                  cpu_region == RegNone);
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (cpu_region)
      RegA:    rd_data = ram_a[cpu_addr[9:0]];
      RegB:    rd_data = ram_b[cpu_addr[9:0]];
      RegVec:  rd_data = vec_q[rd_vidx];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      count_q      <= 2'd0;
      fetch_done_q <= 1'b0;
      rdata_q      <= 8'h00;
      load_ack_q   <= 1'b0;
      unmapped_q   <= 1'b0;
      vec_q[0]     <= 8'h00;
      vec_q[1]     <= 8'h02;
      vec_q[2]     <= 8'hdc;
      vec_q[3]     <= 8'hcc;
      vec_q[4]     <= 8'hca;
      vec_q[5]     <= 8'hcc;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fetch_done_q <= fetch_done_d;
      load_ack_q   <= load_ack_d;
      unmapped_q   <= unmapped_d;
      if (serviced && bus.readNotWrite) rdata_q <= rd_data;
      if (wr_en && wr_region == RegVec) vec_q[wr_vidx] <= wr_data;
    end
  end

  // RAM contents survive reset; only the write itself is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (wr_region == RegA) ram_a[wr_addr[9:0]] <= wr_data;
      if (wr_region == RegB) ram_b[wr_addr[9:0]] <= wr_data;
    end
  end

  assign bus.dataBusInput   = rdata_q;
  assign bus.ready          = (state_q == StRun) && !rst;
  assign bus.loadAck        = load_ack_q;
  assign bus.unmappedAccess = unmapped_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomised and directed bench for cpu_bus_responder against a flat 64 KiB memory model.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mm    [65536];
  bit         known [65536];

  cpu_bus_responder_if bus_if ();

  cpu_bus_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic bit mapped(input int a);
    return (a >= 0 && a <= 'h03ff) || (a >= 'hcc00 && a <= 'hcfff) ||
           (a >= 'hfffa && a <= 'hffff);
  endfunction

  task automatic reset_vectors_model();
    logic [7:0] rv [6];
    rv = '{8'h00, 8'h02, 8'hdc, 8'hcc, 8'hca, 8'hcc};
    for (int i = 0; i < 6; i++) begin
      mm['hfffa + i]    = rv[i];
      known['hfffa + i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [15:0] a, input logic rnw, input logic dbe,
                     input logic [7:0] d, input logic s);
    bus_if.AddressBusHigh = a[15:8];
    bus_if.AddressBusLow  = a[7:0];
    bus_if.readNotWrite   = rnw;
    bus_if.dataBusEnable  = dbe;
    bus_if.dataBusOutput  = d;
    bus_if.sync           = s;
  endtask

  task automatic idle();
    cpu(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    bus_if.loadEnable  = 1'b1;
    bus_if.loadAddress = a;
    bus_if.loadData    = d;
    if (mapped(int'(a))) begin
      mm[a]    = d;
      known[a] = 1'b1;
    end
  endtask

  // Measures the stall length of one opcode fetch and the byte it returns.
  task automatic run_fetch(input logic [15:0] a, input logic [1:0] ws,
                           output int low, output logic [7:0] data);
    bit done = 1'b0;
    bus_if.waitStates = ws;
    cpu(a, 1'b1, 1'b0, 8'h00, 1'b1);
    low = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      tick();
      if (bus_if.ready === 1'b1) done = 1'b1;
      else low++;
    end
    if (!done) low = -1;
    if (low > 0) tick();
    data = bus_if.dataBusInput;
    cpu(a, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (bus_if.ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b want=0", bus_if.ready);
    end
    checks++;
    if (bus_if.dataBusInput !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h want=00", bus_if.dataBusInput);
    end
    checks++;
    if (bus_if.loadAck !== 1'b0 || bus_if.unmappedAccess !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got ack=%b unm=%b want 0 0", bus_if.loadAck,
               bus_if.unmappedAccess);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", bus_if.ready);
    end
    tick();
    checks++;
    if (bus_if.ready !== 1'b1) begin
      failures++; $display("FAIL after_reset_ready got=%b want=1", bus_if.ready);
    end
  endtask

  task automatic test_vectors();
    bus_if.waitStates = 2'd0;
    for (int i = 0; i < 6; i++) begin
      int a = 'hfffa + ((i + 2) % 6);
      cpu(16'(a), 1'b1, 1'b0, 8'h00, 1'b1);
      tick();
      checks++;
      if (bus_if.dataBusInput !== mm[a] || bus_if.ready !== 1'b1) begin
        failures++;
        $display("FAIL vector_read addr=%h got=%h ready=%b want=%h ready=1", a,
                 bus_if.dataBusInput, bus_if.ready, mm[a]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_preload_fetch();
    int low;
    logic [7:0] d;
    load(16'hccdc, 8'ha9);
    tick();
    checks++;
    if (bus_if.loadAck !== 1'b1 || bus_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL preload_ack1 got ack=%b ready=%b want 1 0", bus_if.loadAck, bus_if.ready);
    end
    load(16'hccdd, 8'h7f);
    tick();
    checks++;
    if (bus_if.loadAck !== 1'b1) begin
      failures++; $display("FAIL preload_ack2 got=%b want=1", bus_if.loadAck);
    end
    bus_if.loadEnable = 1'b0;
    tick();
    checks++;
    if (bus_if.loadAck !== 1'b0 || bus_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL preload_release got ack=%b ready=%b want 0 1", bus_if.loadAck,
               bus_if.ready);
    end
    run_fetch(16'hccdc, 2'd2, low, d);
    checks++;
    if (low != 2 || d !== 8'ha9) begin
      failures++; $display("FAIL fetch_ws2 got low=%0d data=%h want 2 a9", low, d);
    end
    bus_if.waitStates = 2'd2;
    cpu(16'hccdd, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h7f || bus_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL nosync_read got=%h ready=%b want 7f 1", bus_if.dataBusInput, bus_if.ready);
    end
    run_fetch(16'hccdc, 2'd2, low, d);
    checks++;
    if (low != 2 || d !== 8'ha9) begin
      failures++; $display("FAIL refetch_ws2 got low=%0d data=%h want 2 a9", low, d);
    end
    run_fetch(16'hccdd, 2'd1, low, d);
    checks++;
    if (low != 1 || d !== 8'h7f) begin
      failures++; $display("FAIL fetch_ws1 got low=%0d data=%h want 1 7f", low, d);
    end
    run_fetch(16'hccdc, 2'd3, low, d);
    checks++;
    if (low != 3 || d !== 8'ha9) begin
      failures++; $display("FAIL fetch_ws3 got low=%0d data=%h want 3 a9", low, d);
    end
  endtask

  task automatic test_cpu_write();
    bus_if.waitStates = 2'd0;
    cpu(16'hfffa, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    cpu(16'h01ff, 1'b0, 1'b1, 8'h55, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== mm['hfffa] || bus_if.unmappedAccess !== 1'b0) begin
      failures++;
      $display("FAIL write_holds_data got=%h unm=%b want=%h 0", bus_if.dataBusInput,
               bus_if.unmappedAccess, mm['hfffa]);
    end
    mm['h01ff] = 8'h55; known['h01ff] = 1'b1;
    cpu(16'h01ff, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h55) begin
      failures++; $display("FAIL write_readback got=%h want=55", bus_if.dataBusInput);
    end
    cpu(16'h01ff, 1'b0, 1'b0, 8'haa, 1'b0);
    tick();
    cpu(16'h01ff, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h55) begin
      failures++; $display("FAIL write_no_enable got=%h want=55", bus_if.dataBusInput);
    end
    idle();
  endtask

  task automatic test_unmapped();
    logic [15:0] edges [4];
    edges = '{16'h0400, 16'hcbff, 16'hd000, 16'hfff9};
    cpu(16'h0000, 1'b0, 1'b1, 8'h21, 1'b0);
    tick();
    mm[0] = 8'h21; known[0] = 1'b1;
    cpu(16'h8000, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h00 || bus_if.unmappedAccess !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_read got=%h unm=%b want 00 1", bus_if.dataBusInput,
               bus_if.unmappedAccess);
    end
    idle();
    tick();
    checks++;
    if (bus_if.unmappedAccess !== 1'b0) begin
      failures++; $display("FAIL unmapped_pulse_width got=%b want=0", bus_if.unmappedAccess);
    end
    cpu(16'h4000, 1'b0, 1'b1, 8'h77, 1'b0);
    tick();
    checks++;
    if (bus_if.unmappedAccess !== 1'b1) begin
      failures++; $display("FAIL unmapped_write got=%b want=1", bus_if.unmappedAccess);
    end
    cpu(16'h4000, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h00 || bus_if.unmappedAccess !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_readback got=%h unm=%b want 00 1", bus_if.dataBusInput,
               bus_if.unmappedAccess);
    end
    cpu(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h21) begin
      failures++; $display("FAIL unmapped_no_alias got=%h want=21", bus_if.dataBusInput);
    end
    for (int i = 0; i < 4; i++) begin
      cpu(edges[i], 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      checks++;
      if (bus_if.dataBusInput !== 8'h00 || bus_if.unmappedAccess !== 1'b1) begin
        failures++;
        $display("FAIL unmapped_edge addr=%h got=%h unm=%b want 00 1", edges[i],
                 bus_if.dataBusInput, bus_if.unmappedAccess);
      end
    end
    idle();
    load(16'h8000, 8'h5a);
    tick();
    checks++;
    if (bus_if.loadAck !== 1'b0 || bus_if.unmappedAccess !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_load got ack=%b unm=%b want 0 1", bus_if.loadAck,
               bus_if.unmappedAccess);
    end
    bus_if.loadEnable = 1'b0;
    tick();
  endtask

  task automatic test_load_during_stall();
    int low;
    logic [7:0] d;
    load(16'h0200, 8'hea);
    tick();
    bus_if.loadEnable = 1'b0;
    tick();
    bus_if.waitStates = 2'd3;
    cpu(16'h0200, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checks++;
    if (bus_if.ready !== 1'b0) begin
      failures++; $display("FAIL stall_ready got=%b want=0", bus_if.ready);
    end
    load(16'h0201, 8'h11);
    tick();
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.loadAck !== 1'b1) begin
      failures++;
      $display("FAIL stall_load1 got ready=%b ack=%b want 0 1", bus_if.ready, bus_if.loadAck);
    end
    load(16'h0202, 8'h22);
    tick();
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.loadAck !== 1'b1) begin
      failures++;
      $display("FAIL stall_load2 got ready=%b ack=%b want 0 1", bus_if.ready, bus_if.loadAck);
    end
    bus_if.loadEnable = 1'b0;
    tick();
    run_fetch(16'h0200, 2'd3, low, d);
    checks++;
    if (low != 3 || d !== 8'hea) begin
      failures++; $display("FAIL stall_restart got low=%0d data=%h want 3 ea", low, d);
    end
    bus_if.waitStates = 2'd0;
    cpu(16'h0201, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h11) begin
      failures++; $display("FAIL stall_load_data got=%h want=11", bus_if.dataBusInput);
    end
    idle();
  endtask

  task automatic test_reset_vectors();
    int low;
    logic [7:0] d;
    bus_if.waitStates = 2'd0;
    cpu(16'hfffe, 1'b0, 1'b1, 8'h34, 1'b0); tick();
    cpu(16'h0123, 1'b0, 1'b1, 8'h5a, 1'b0); tick();
    cpu(16'h0124, 1'b0, 1'b1, 8'h42, 1'b0); tick();
    cpu(16'hfffe, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h34) begin
      failures++; $display("FAIL vector_write got=%h want=34", bus_if.dataBusInput);
    end
    idle();
    rst = 1'b1;
    bus_if.loadEnable  = 1'b1;
    bus_if.loadAddress = 16'h0124;
    bus_if.loadData    = 8'h99;
    tick();
    checks++;
    if (bus_if.loadAck !== 1'b0 || bus_if.ready !== 1'b0 || bus_if.dataBusInput !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_load got ack=%b ready=%b data=%h want 0 0 00", bus_if.loadAck,
               bus_if.ready, bus_if.dataBusInput);
    end
    rst = 1'b0;
    bus_if.loadEnable = 1'b0;
    mm['h0123] = 8'h5a; mm['h0124] = 8'h42;
    reset_vectors_model();
    cpu(16'hfffe, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    checks++;
    if (bus_if.dataBusInput !== 8'hca) begin
      failures++; $display("FAIL vector_after_reset got=%h want=ca", bus_if.dataBusInput);
    end
    cpu(16'h0123, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h5a) begin
      failures++; $display("FAIL ram_keeps_value got=%h want=5a", bus_if.dataBusInput);
    end
    cpu(16'h0124, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    checks++;
    if (bus_if.dataBusInput !== 8'h42) begin
      failures++; $display("FAIL reset_load_dropped got=%h want=42", bus_if.dataBusInput);
    end
    bus_if.waitStates = 2'd3;
    cpu(16'h0123, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_fetch(16'h0123, 2'd3, low, d);
    checks++;
    if (low != 3 || d !== 8'h5a) begin
      failures++; $display("FAIL reset_mid_stall got low=%0d data=%h want 3 5a", low, d);
    end
  endtask

  task automatic test_random();
    bus_if.waitStates = 2'd0;
    for (int n = 0; n < 200; n++) begin
      int op   = $urandom_range(0, 3);
      int kind = $urandom_range(0, 3);
      int a;
      logic [7:0] d = 8'($urandom);
      bit m;
      unique case (kind)
        0:       a = $urandom_range(0, 'h03ff);
        1:       a = 'hcc00 + $urandom_range(0, 'h03ff);
        2:       a = 'hfffa + $urandom_range(0, 5);
        default: a = $urandom_range('h0400, 'hcbff);
      endcase
      m = mapped(a);
      if (op == 3) begin
        load(16'(a), d);
        tick();
        checks++;
        if (bus_if.loadAck !== m || bus_if.unmappedAccess !== !m || bus_if.ready !== 1'b0) begin
          failures++;
          $display("FAIL rand_load addr=%h got ack=%b unm=%b ready=%b want %b %b 0", a,
                   bus_if.loadAck, bus_if.unmappedAccess, bus_if.ready, m, !m);
        end
        bus_if.loadEnable = 1'b0;
        tick();
        checks++;
        if (bus_if.ready !== 1'b1 || bus_if.loadAck !== 1'b0) begin
          failures++;
          $display("FAIL rand_load_exit got ready=%b ack=%b want 1 0", bus_if.ready,
                   bus_if.loadAck);
        end
      end else begin
        logic rnw = (op == 0);
        logic dbe = (op == 1);
        cpu(16'(a), rnw, dbe, d, 1'($urandom));
        tick();
        if (op == 1 && m) begin
          mm[a] = d; known[a] = 1'b1;
        end
        checks++;
        if (bus_if.unmappedAccess !== ((op != 2) && !m) || bus_if.ready !== 1'b1) begin
          failures++;
          $display("FAIL rand_cpu op=%0d addr=%h got unm=%b ready=%b want %b 1", op, a,
                   bus_if.unmappedAccess, bus_if.ready, (op != 2) && !m);
        end
        if (op == 0 && (known[a] || !m)) begin
          logic [7:0] exp = m ? mm[a] : 8'h00;
          checks++;
          if (bus_if.dataBusInput !== exp) begin
            failures++;
            $display("FAIL rand_read addr=%h got=%h want=%h", a, bus_if.dataBusInput, exp);
          end
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus_if.waitStates  = 2'd0;
    bus_if.loadEnable  = 1'b0;
    bus_if.loadAddress = 16'h0000;
    bus_if.loadData    = 8'h00;
    reset_vectors_model();
    test_reset();
    test_vectors();
    test_preload_fetch();
    test_cpu_write();
    test_unmapped();
    test_load_during_stall();
    test_reset_vectors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
